// File: rtl/buzz_arbiter_pkg.sv
// Shared definitions for the four-player buzzer arbiter.
// Contents: player count/ID width, FSM state encoding, the exmem I/O word
// addresses the arbiter outputs are mapped to, and the round-robin pick helper.
package buzz_arbiter_pkg;

   localparam int NUM_PLAYERS = 4;
   localparam int PLAYER_ID_W = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   // exmem I/O words driven by the arbiter
   localparam logic [9:0] ADDR_FIRST_PLAYER = 10'd529;
   localparam logic [9:0] ADDR_PLAYER_INPUT = 10'd530;
   localparam logic [9:0] ADDR_ALL_BUTTONS  = 10'd537;

   // Returns {found, id}. Scans from the highest offset down so the last
   // hit written is the one closest to ptr, i.e. the highest priority.
   function automatic logic [PLAYER_ID_W:0] rr_pick(
      input logic [NUM_PLAYERS-1:0] req,
      input logic [PLAYER_ID_W-1:0] ptr
   );
      logic [PLAYER_ID_W:0]   r;
      logic [PLAYER_ID_W-1:0] idx;
      r = '0;
      for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
         idx = ptr + k[PLAYER_ID_W-1:0];
         if (req[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

endpackage

// File: rtl/buzz_arbiter_debounce.sv
// Per-button input conditioning: 2-FF synchroniser, debounce counter and a
// registered one-cycle rising-edge pulse of the debounced level.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   btn_raw   - raw asynchronous button, active-high
//   level     - debounced button level
//   rise      - 1-cycle pulse, one cycle after level goes high
module buzz_arbiter_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   logic        sync1;
   logic        sync2;
   logic        level_d;
   logic [15:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         rise    <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_d <= level;
         rise    <= level & ~level_d;
         // Any cycle agreeing with the current level restarts the count.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (({1'b0, cnt} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/buzz_arbiter.sv
// Four-player buzzer arbiter. Debounces the player buttons, opens a buzz
// window on arm, latches the first (round-robin resolved) winner until clear.
//
// state  | meaning
// IDLE   | no window open; rises ignored
// ARMED  | window open; first rise wins, optional timeout
// LOCKED | winner latched until clear
//
// Ports:
//   clk, rst        - system clock, async active-high reset
//   buttons[3:0]    - raw player buttons (async, active-high)
//   arm             - pulse: open a window (gated by gameHasStarted)
//   clear           - pulse: release winner / close window
//   gameHasStarted  - level enabling arm
//   firstPlayerFlag - winner ID, valid while playerInputFlag
//   playerInputFlag - winner latched
//   allButtons      - all four debounced buttons held
//   timedOut        - sticky: last window expired with no press
//   armed           - window open
module buzz_arbiter
   import buzz_arbiter_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PLAYERS-1:0] buttons,
   input  logic                   arm,
   input  logic                   clear,
   input  logic                   gameHasStarted,
   output logic [PLAYER_ID_W-1:0] firstPlayerFlag,
   output logic                   playerInputFlag,
   output logic                   allButtons,
   output logic                   timedOut,
   output logic                   armed
);

   logic [NUM_PLAYERS-1:0] level;
   logic [NUM_PLAYERS-1:0] rise;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_btn
      buzz_arbiter_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(buttons[i]),
         .level  (level[i]),
         .rise   (rise[i])
      );
   end

   state_t                 state, state_nx;
   logic [31:0]            timer, timer_nx;
   logic [PLAYER_ID_W-1:0] rr_ptr, rr_ptr_nx;
   logic [PLAYER_ID_W-1:0] winner, winner_nx;
   logic                   timed_out, timed_out_nx;
   logic [PLAYER_ID_W:0]   pick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         rr_ptr     <= '0;
         winner     <= '0;
         timed_out  <= 1'b0;
         allButtons <= 1'b0;
      end else begin
         state      <= state_nx;
         timer      <= timer_nx;
         rr_ptr     <= rr_ptr_nx;
         winner     <= winner_nx;
         timed_out  <= timed_out_nx;
         allButtons <= &level;
      end
   end

   always_comb begin
      state_nx     = state;
      timer_nx     = timer;
      rr_ptr_nx    = rr_ptr;
      winner_nx    = winner;
      timed_out_nx = timed_out;
      pick         = rr_pick(rise, rr_ptr);
      case (state)
         S_IDLE: begin
            if (arm && gameHasStarted && !clear) begin
               state_nx     = S_ARMED;
               timed_out_nx = 1'b0;
               timer_nx     = '0;
            end
         end
         S_ARMED: begin
            // Priority: clear, then a win, then the timeout.
            if (clear) begin
               state_nx = S_IDLE;
            end else if (pick[PLAYER_ID_W]) begin
               state_nx  = S_LOCKED;
               winner_nx = pick[PLAYER_ID_W-1:0];
               rr_ptr_nx = pick[PLAYER_ID_W-1:0] + 1'b1;
            end else if ((TIMEOUT_CYCLES != 32'd0) && (timer == TIMEOUT_CYCLES - 32'd1)) begin
               state_nx     = S_IDLE;
               timed_out_nx = 1'b1;
            end else begin
               timer_nx = timer + 32'd1;
            end
         end
         S_LOCKED: begin
            if (clear) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Flags decode straight from the state register so they drop on the
   // same edge the FSM leaves LOCKED.
   assign playerInputFlag = (state == S_LOCKED);
   assign firstPlayerFlag = (state == S_LOCKED) ? winner : '0;
   assign armed           = (state == S_ARMED);
   assign timedOut        = timed_out;

endmodule

// File: tb/tb_buzz_arbiter.sv
module tb_buzz_arbiter;

   localparam logic [15:0] DEB       = 16'd4;
   localparam logic [31:0] TMO       = 32'd20;
   localparam int          PRESS_LAT = 2 + 4 + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] buttons;
   logic       arm;
   logic       clear;
   logic       gameHasStarted;
   logic [1:0] firstPlayerFlag;
   logic       playerInputFlag;
   logic       allButtons;
   logic       timedOut;
   logic       armed;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;

   buzz_arbiter #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .buttons        (buttons),
      .arm            (arm),
      .clear          (clear),
      .gameHasStarted (gameHasStarted),
      .firstPlayerFlag(firstPlayerFlag),
      .playerInputFlag(playerInputFlag),
      .allButtons     (allButtons),
      .timedOut       (timedOut),
      .armed          (armed)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // First pressed player in round-robin order starting at ptr.
   function automatic int model_winner(input logic [3:0] mask, input int ptr);
      for (int k = 0; k < 4; k++) begin
         int p;
         p = (ptr + k) % 4;
         if (mask[p]) return p;
      end
      return -1;
   endfunction

   task automatic pulse_arm();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   task automatic release_all();
      buttons = 4'b0000;
      tick(10);
   endtask

   // Arm, press a set of players simultaneously, check latency and winner.
   task automatic window(input logic [3:0] mask, input string tag);
      int exp;
      pulse_arm();
      chk({tag, "_armed"}, armed, 1);
      chk({tag, "_timedout_clr"}, timedOut, 0);
      buttons = mask;
      tick(PRESS_LAT - 1);
      chk({tag, "_flag_early"}, playerInputFlag, 0);
      tick(1);
      exp = model_winner(mask, m_ptr);
      chk({tag, "_flag"}, playerInputFlag, 1);
      chk({tag, "_id"}, firstPlayerFlag, exp);
      m_ptr = (exp + 1) % 4;
      pulse_clear();
      chk({tag, "_cleared"}, playerInputFlag, 0);
      release_all();
   endtask

   initial begin
      rst            = 1'b1;
      buttons        = 4'b0000;
      arm            = 1'b0;
      clear          = 1'b0;
      gameHasStarted = 1'b0;
      tick(2);
      chk("rst_flag", playerInputFlag, 0);
      chk("rst_id", firstPlayerFlag, 0);
      chk("rst_all", allButtons, 0);
      chk("rst_to", timedOut, 0);
      chk("rst_armed", armed, 0);
      rst = 1'b0;
      tick(2);

      // arm ignored while game not started
      pulse_arm();
      chk("gate_armed", armed, 0);
      gameHasStarted = 1'b1;

      // 1: clean press of player 2
      window(4'b0100, "t1");
      // 2: simultaneous 0 and 3 with rr_ptr=3, then rr_ptr=0
      window(4'b1001, "t2a");
      window(4'b1001, "t2b");

      // randomized simultaneous presses
      for (int r = 0; r < 6; r++) begin
         logic [3:0] m;
         m = 4'($urandom_range(1, 15));
         window(m, $sformatf("rnd%0d", r));
      end

      // 3: bouncing player 1
      pulse_arm();
      repeat (2) begin
         buttons[1] = 1'b1;
         tick(3);
         buttons[1] = 1'b0;
         tick(1);
      end
      chk("t3_bounce_flag", playerInputFlag, 0);
      buttons[1] = 1'b1;
      tick(PRESS_LAT - 1);
      chk("t3_flag_early", playerInputFlag, 0);
      tick(1);
      chk("t3_flag", playerInputFlag, 1);
      chk("t3_id", firstPlayerFlag, 1);
      m_ptr = 2;
      pulse_clear();
      release_all();

      // 4: held before arm cannot win; timeout
      buttons[0] = 1'b1;
      tick(10);
      pulse_arm();
      chk("t4_armed", armed, 1);
      tick(19);
      chk("t4_armed_pre_to", armed, 1);
      chk("t4_to_pre", timedOut, 0);
      tick(1);
      chk("t4_armed_post_to", armed, 0);
      chk("t4_to", timedOut, 1);
      chk("t4_flag", playerInputFlag, 0);
      release_all();
      window(4'b0001, "t4_repress");

      // rise on the same edge as the timeout: rise wins
      pulse_arm();
      tick(12);
      buttons = 4'b0100;
      tick(PRESS_LAT);
      chk("tr_flag", playerInputFlag, 1);
      chk("tr_id", firstPlayerFlag, 2);
      chk("tr_to", timedOut, 0);
      chk("tr_armed", armed, 0);
      m_ptr = 3;
      pulse_clear();
      release_all();

      // 5: LOCKED ignores further presses and arm
      pulse_arm();
      buttons = 4'b0010;
      tick(PRESS_LAT);
      chk("t5_id", firstPlayerFlag, 1);
      m_ptr = 2;
      buttons = 4'b0110;
      tick(10);
      chk("t5_hold_flag", playerInputFlag, 1);
      chk("t5_hold_id", firstPlayerFlag, 1);
      pulse_arm();
      chk("t5_arm_id", firstPlayerFlag, 1);
      chk("t5_arm_armed", armed, 0);
      pulse_clear();
      chk("t5_clr_flag", playerInputFlag, 0);
      chk("t5_clr_id", firstPlayerFlag, 0);
      chk("t5_clr_armed", armed, 0);
      // arm and clear together in IDLE: clear wins
      arm   = 1'b1;
      clear = 1'b1;
      tick(1);
      arm   = 1'b0;
      clear = 1'b0;
      chk("armclr_armed", armed, 0);
      release_all();

      // 6: async reset while ARMED and while LOCKED
      pulse_arm();
      chk("t6_armed", armed, 1);
      #2 rst = 1'b1;
      #1 chk("t6_rst_armed", armed, 0);
      rst = 1'b0;
      tick(1);
      pulse_arm();
      buttons = 4'b0010;
      tick(PRESS_LAT);
      chk("t6_lock_id", firstPlayerFlag, 1);
      #2 rst = 1'b1;
      #1 chk("t6_rst_flag", playerInputFlag, 0);
      chk("t6_rst_id", firstPlayerFlag, 0);
      chk("t6_rst_armed2", armed, 0);
      buttons = 4'b0000;
      rst = 1'b0;
      m_ptr = 0;
      tick(10);
      window(4'b1010, "t6_ptr");

      // allButtons independent of state
      buttons = 4'hF;
      tick(6);
      chk("all_early", allButtons, 0);
      tick(1);
      chk("all_idle", allButtons, 1);
      pulse_arm();
      chk("all_armed", allButtons, 1);
      buttons = 4'h0;
      tick(6);
      chk("all_rel_early", allButtons, 1);
      tick(1);
      chk("all_rel", allButtons, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
